// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 types, constants and round/key-schedule primitives
package aes_pkg;

  localparam int         AES_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT  = 8'h01;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box from its algebraic definition: x^254 (inverse, 0 -> 0) then the affine map.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sub_byte(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte 4c+r holds row r of column c; row r rotates left by r columns.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic aes_block_t add_round_key(input aes_block_t s, input aes_block_t k);
    return s ^ k;
  endfunction

  function automatic aes_block_t key_expansion(input aes_block_t rk, input logic [31:0] rcon_w);
    logic [31:0] w0, w1, w2, w3, t;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ rcon_w;
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// rtl/aes_enc_round.sv - one AES encryption round; MixColumns skipped on the final round
module aes_enc_round
  import aes_pkg::*;
(
  input  aes_block_t blk_i,
  input  aes_block_t rk_i,
  input  logic       last_i,
  output aes_block_t blk_o
);

  aes_block_t sr;

  assign sr    = shift_rows(sub_bytes(blk_i));
  assign blk_o = add_round_key(last_i ? sr : mix_columns(sr), rk_i);

endmodule

// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encrypt core, keys expanded on the fly
// AES_UNROLL2_EN: chain two rounds per ROUND cycle (five cycles per block).
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter bit CLEAR_ON_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  aes_state_e state_q, state_d;
  aes_block_t st_q, st_d;
  aes_block_t rk_q, rk_d;
  logic [7:0] rcon_q, rcon_d;
  logic [3:0] rnd_q, rnd_d;

  aes_block_t rk1;
  aes_block_t st_step;
  aes_block_t rk_step;
  logic [7:0] rcon_step;
  logic       last_rnd;

  assign rk1 = key_expansion(rk_q, {rcon_q, 24'h0});

`ifdef AES_UNROLL2_EN
  localparam logic [3:0] RND_STEP = 4'd2;
  aes_block_t st1;
  aes_block_t rk2;
  logic [7:0] rcon2;

  // rnd_q tracks the first round of each pair: 1,3,5,7,9.
  assign last_rnd  = (rnd_q == 4'(AES_ROUNDS - 1));
  assign rcon2     = xtime(rcon_q);
  assign rk2       = key_expansion(rk1, {rcon2, 24'h0});
  assign rk_step   = rk2;
  assign rcon_step = xtime(rcon2);

  aes_enc_round u_round1 (
    .blk_i (st_q),
    .rk_i  (rk1),
    .last_i(1'b0),
    .blk_o (st1)
  );

  aes_enc_round u_round2 (
    .blk_i (st1),
    .rk_i  (rk2),
    .last_i(last_rnd),
    .blk_o (st_step)
  );
`else
  localparam logic [3:0] RND_STEP = 4'd1;

  assign last_rnd  = (rnd_q == 4'(AES_ROUNDS));
  assign rk_step   = rk1;
  assign rcon_step = xtime(rcon_q);

  aes_enc_round u_round (
    .blk_i (st_q),
    .rk_i  (rk1),
    .last_i(last_rnd),
    .blk_o (st_step)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rcon_q  <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ROUND;
          st_d    = in_data ^ in_key;
          rk_d    = in_key;
          rcon_d  = RCON_INIT;
          rnd_d   = 4'd1;
        end
      end
      ROUND: begin
        st_d   = st_step;
        rk_d   = rk_step;
        rcon_d = rcon_step;
        if (last_rnd) state_d = DONE;
        else          rnd_d   = rnd_q + RND_STEP;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (CLEAR_ON_IDLE) begin
            st_d   = '0;
            rk_d   = '0;
            rcon_d = '0;
            rnd_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        st_d    = '0;
        rk_d    = '0;
        rcon_d  = '0;
        rnd_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == ROUND) || (state_q == DONE);
    out_data  = (state_q == DONE) ? st_q : '0;
  end

endmodule
